// File: rtl/iic_eeprom_arbiter.sv
// Round-robin arbiter that sequences single-byte commands from two requesters onto the 24LC64 IIC engine.
// Latency: eng_start 2 cycles after grant sample, done 2 cycles after eng_done; requests wait while busy (incl. write hold-off).
module iic_eeprom_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int TWR_CYC     = 250000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [7:0]        wdata0,
  output logic              done0,
  output logic [7:0]        rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata1,
  output logic              done1,
  output logic [7:0]        rdata1,
  output logic              err1,
  output logic              eng_start,
  output logic              eng_rw,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [7:0]        eng_wdata,
  input  logic              eng_done,
  input  logic [7:0]        eng_rdata,
  input  logic              eng_nack,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, TWR} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TWR_LAST     = CNT_W'(TWR_CYC - 1);

  state_t           state;
  logic             gnt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rdata_q;
  logic             err_q;
  logic             rd_upd;
  logic             pick;

  // On a tie the port that was not served last wins, giving strict alternation.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_upd     <= 1'b0;
      done0      <= 1'b0;
      rdata0     <= '0;
      err0       <= 1'b0;
      done1      <= 1'b0;
      rdata1     <= '0;
      err1       <= 1'b0;
      eng_start  <= 1'b0;
      eng_rw     <= 1'b0;
      eng_addr   <= '0;
      eng_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= pick;
            last_grant <= pick;
            eng_rw     <= pick ? rw1    : rw0;
            eng_addr   <= pick ? addr1  : addr0;
            eng_wdata  <= pick ? wdata1 : wdata0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start <= 1'b1;
          cnt       <= '0;
          state     <= BUSY;
        end
        BUSY: begin
          // A done arriving on the timeout cycle takes priority over the abort.
          if (eng_done) begin
            rdata_q <= eng_rdata;
            err_q   <= eng_nack;
            rd_upd  <= 1'b1;
            state   <= RESP;
          end else if (cnt == TIMEOUT_LAST) begin
            err_q  <= 1'b1;
            rd_upd <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (gnt) begin
            done1 <= 1'b1;
            err1  <= err_q;
            if (eng_rw && rd_upd) rdata1 <= rdata_q;
          end else begin
            done0 <= 1'b1;
            err0  <= err_q;
            if (eng_rw && rd_upd) rdata0 <= rdata_q;
          end
          if (!eng_rw && !err_q) begin
            cnt   <= '0;
            state <= TWR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        TWR: begin
          // EEPROM is busy with its internal write cycle; keep the bus quiet.
          if (cnt == TWR_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_eeprom_arbiter.sv
// Directed bench for iic_eeprom_arbiter with a behavioural IIC engine responder.
module tb_iic_eeprom_arbiter;
  localparam int ADDR_W = 13;
  localparam int TWR    = 20;
  localparam int TO     = 60;
  localparam int CNT_W  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]        wdata0 = '0, wdata1 = '0;
  logic              done0, err0, done1, err1;
  logic [7:0]        rdata0, rdata1;
  logic              eng_start, eng_rw, busy;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        eng_wdata;
  logic              eng_done, eng_nack;
  logic [7:0]        eng_rdata;

  int tests = 0;
  int fails = 0;

  iic_eeprom_arbiter #(
    .ADDR_W(ADDR_W), .TWR_CYC(TWR), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_nack(eng_nack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine model: answers eng_lat cycles after eng_start with addr[7:0]^rd_key.
  bit         eng_en = 1'b1;
  int         eng_lat = 10;
  logic [7:0] rd_key = 8'h00;
  bit         nack_val = 1'b0;
  int         stray_req = 0;
  int         stray_ack = 0;
  bit         pend = 1'b0;
  int         left = 0;

  initial begin
    eng_done  = 1'b0;
    eng_rdata = 8'h00;
    eng_nack  = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        eng_done  = 1'b1;
        eng_rdata = 8'hEE;
        eng_nack  = 1'b1;
      end else if (eng_start && eng_en) begin
        pend = 1'b1;
        left = eng_lat;
      end else if (pend) begin
        left--;
        if (left == 0) begin
          pend      = 1'b0;
          eng_done  = 1'b1;
          eng_rdata = eng_addr[7:0] ^ rd_key;
          eng_nack  = nack_val;
        end
      end
    end
  end

  // Event monitor, sampled just after each rising edge.
  int cyc = 0, n_start = 0, n_done0 = 0, n_done1 = 0;
  int t_start = 0, t_done0 = 0, t_done1 = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (eng_start) begin n_start++; t_start = cyc; end
      if (done0)     begin n_done0++; t_done0 = cyc; end
      if (done1)     begin n_done1++; t_done1 = cyc; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((p == 0 && done0) || (p == 1 && done1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int s0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_start != s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({done0, done1, err0, err1, rdata0, rdata1, eng_start, eng_rw, eng_addr, eng_wdata, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b eng_addr=%h rdata0=%h rdata1=%h, expected all zero",
               busy, eng_addr, rdata0, rdata1);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || n_start != 0) begin
      fails++;
      $display("FAIL idle_no_req: got busy=%b starts=%0d, expected 0/0", busy, n_start);
    end
  endtask

  task automatic test_read_port0();
    bit ok;
    int s0 = n_start, d1 = n_done1;
    eng_lat = 40; rd_key = 8'h79;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 13'h0123;
    wait_done(0, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL read0_done: got no done0, expected done0"); end
    tests++;
    if (rdata0 !== 8'h5A || err0 !== 1'b0) begin
      fails++; $display("FAIL read0_data: got rdata0=%h err0=%b, expected 5a/0", rdata0, err0);
    end
    tests++;
    if (n_start - s0 != 1 || t_done0 - t_start != 42) begin
      fails++; $display("FAIL read0_timing: got starts=%0d latency=%0d, expected 1/42",
                        n_start - s0, t_done0 - t_start);
    end
    tests++;
    if (eng_addr !== 13'h0123 || eng_rw !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL read0_eng: got addr=%h rw=%b busy=%b, expected 0123/1/0", eng_addr, eng_rw, busy);
    end
    tests++;
    if (n_done1 != d1 || rdata1 !== 8'h00 || err1 !== 1'b0) begin
      fails++; $display("FAIL read0_port1_quiet: got done1s=%0d rdata1=%h, expected 0/00", n_done1 - d1, rdata1);
    end
    req0 = 1'b0;
  endtask

  task automatic test_both_reads();
    bit ok = 1'b0;
    int s0, td0;
    do_reset();
    s0 = n_start;
    eng_lat = 5; rd_key = 8'h00;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 13'h0010;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 13'h0020;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done0 || done1) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || done0 !== 1'b1 || done1 !== 1'b0 || rdata0 !== 8'h10) begin
      fails++; $display("FAIL tie_first: got done0=%b done1=%b rdata0=%h, expected 1/0/10", done0, done1, rdata0);
    end
    td0 = t_done0;
    req0 = 1'b0;
    wait_done(1, 100, ok);
    tests++;
    if (!ok || rdata1 !== 8'h20 || err1 !== 1'b0) begin
      fails++; $display("FAIL tie_second: got ok=%b rdata1=%h err1=%b, expected 1/20/0", ok, rdata1, err1);
    end
    tests++;
    if (n_start - s0 != 2 || t_start <= td0) begin
      fails++; $display("FAIL tie_no_overlap: got starts=%0d start2=%0d done0=%0d, expected 2 and start2>done0",
                        n_start - s0, t_start, td0);
    end
    req1 = 1'b0;
  endtask

  task automatic test_write_twr();
    bit ok;
    int s0 = n_start, td1;
    eng_lat = 8; nack_val = 1'b0;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 13'h1FFF; wdata1 = 8'hA5;
    wait_start(s0, 20, ok);
    req0 = 1'b1; rw0 = 1'b1; addr0 = 13'h0042;
    wait_done(1, 100, ok);
    tests++;
    if (!ok || err1 !== 1'b0 || done0 !== 1'b0) begin
      fails++; $display("FAIL write1_done: got ok=%b err1=%b done0=%b, expected 1/0/0", ok, err1, done0);
    end
    tests++;
    if ({eng_rw, eng_addr, eng_wdata} !== {1'b0, 13'h1FFF, 8'hA5} || rdata1 !== 8'h20) begin
      fails++; $display("FAIL write1_eng: got rw=%b addr=%h wdata=%h rdata1=%h, expected 0/1fff/a5/20",
                        eng_rw, eng_addr, eng_wdata, rdata1);
    end
    td1 = t_done1;
    req1 = 1'b0;
    s0 = n_start;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || n_start != s0) begin
      fails++; $display("FAIL twr_holdoff: got busy=%b starts=%0d, expected 1/0", busy, n_start - s0);
    end
    wait_start(s0, TWR + 20, ok);
    tests++;
    if (!ok || t_start - td1 != TWR + 2) begin
      fails++; $display("FAIL twr_gap: got ok=%b gap=%0d, expected 1/%0d", ok, t_start - td1, TWR + 2);
    end
    wait_done(0, 100, ok);
    tests++;
    if (!ok || rdata0 !== 8'h42 || err0 !== 1'b0) begin
      fails++; $display("FAIL pending_read0: got ok=%b rdata0=%h err0=%b, expected 1/42/0", ok, rdata0, err0);
    end
    req0 = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    eng_en = 1'b0;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 13'h0100; wdata0 = 8'h11;
    wait_done(0, TO + 40, ok);
    tests++;
    if (!ok || err0 !== 1'b1 || t_done0 - t_start != TO + 1) begin
      fails++; $display("FAIL timeout: got ok=%b err0=%b latency=%0d, expected 1/1/%0d",
                        ok, err0, t_done0 - t_start, TO + 1);
    end
    tests++;
    if (busy !== 1'b0 || rdata0 !== 8'h42) begin
      fails++; $display("FAIL timeout_no_twr: got busy=%b rdata0=%h, expected 0/42", busy, rdata0);
    end
    req0 = 1'b0;
    eng_en = 1'b1;
  endtask

  task automatic test_nack_write();
    bit ok;
    nack_val = 1'b1; eng_lat = 4;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 13'h0005; wdata1 = 8'h77;
    wait_done(1, 100, ok);
    tests++;
    if (!ok || err1 !== 1'b1 || busy !== 1'b0 || rdata1 !== 8'h20) begin
      fails++; $display("FAIL nack_write: got ok=%b err1=%b busy=%b rdata1=%h, expected 1/1/0/20",
                        ok, err1, busy, rdata1);
    end
    tests++;
    if (err0 !== 1'b1 || rdata0 !== 8'h42) begin
      fails++; $display("FAIL nack_port0_quiet: got err0=%b rdata0=%h, expected 1/42", err0, rdata0);
    end
    req1 = 1'b0;
    nack_val = 1'b0;
  endtask

  task automatic test_stray_done();
    int d0 = n_done0, d1 = n_done1;
    @(negedge clk);
    stray_req++;
    repeat (5) @(negedge clk);
    tests++;
    if (n_done0 != d0 || n_done1 != d1 || busy !== 1'b0 || rdata1 !== 8'h20) begin
      fails++; $display("FAIL stray_done: got done0s=%0d done1s=%0d busy=%b rdata1=%h, expected 0/0/0/20",
                        n_done0 - d0, n_done1 - d1, busy, rdata1);
    end
  endtask

  task automatic test_reset_busy();
    bit ok;
    int s0 = n_start, d0;
    eng_lat = 30; rd_key = 8'h00;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 13'h0033;
    wait_start(s0, 20, ok);
    repeat (5) @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 13'h0077;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({done0, done1, err0, err1, rdata0, rdata1, eng_start, eng_rw, eng_addr, eng_wdata, busy} !== '0) begin
      fails++; $display("FAIL reset_busy_outputs: got busy=%b eng_addr=%h rdata0=%h, expected all zero",
                        busy, eng_addr, rdata0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_start;
    d0 = n_done0;
    wait_done(1, 100, ok);
    tests++;
    if (!ok || eng_addr !== 13'h0077 || rdata1 !== 8'h77 || n_start - s0 != 1 || n_done0 != d0) begin
      fails++; $display("FAIL reset_then_req1: got ok=%b addr=%h rdata1=%h starts=%0d done0s=%0d, expected 1/0077/77/1/0",
                        ok, eng_addr, rdata1, n_start - s0, n_done0 - d0);
    end
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_port0();
    test_both_reads();
    test_write_twr();
    test_timeout();
    test_nack_write();
    test_stray_done();
    test_reset_busy();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
